// File: rtl/zsram_pkg.sv
// Shared types and defaults for the one-bit-cell SRAM access sequencer.
package zsram_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_SETTLE = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WSETUP  = 3'd1,
        ST_WSTROBE = 3'd2,
        ST_WHOLD   = 3'd3,
        ST_RSTROBE = 3'd4,
        ST_RESP    = 3'd5
    } zsram_state_t;

    function automatic int zsram_cells(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/zsram_onehot_decoder.sv
// Address to one-hot cell select, all zero when disabled.
module zsram_onehot_decoder #(
    parameter int ADDR_W = 4
) (
    input  logic                   i_en,
    input  logic [ADDR_W-1:0]      i_addr,
    output logic [2**ADDR_W-1:0]   o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) o_onehot[i_addr] = 1'b1;
    end

endmodule

// File: rtl/zsram_access_sequencer.sv
// Sequences single-bit reads and writes onto a bank of strobed one-bit cells.
module zsram_access_sequencer
    import zsram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic                      Crystal50Mhz1,
    input  logic                      nReset,
    input  logic                      ReqValid,
    output logic                      ReqReady,
    input  logic                      ReqWrite,
    input  logic [ADDR_W-1:0]         ReqAddr,
    input  logic                      ReqData,
    output logic                      RspValid,
    input  logic                      RspReady,
    output logic                      RspData,
    output logic [2**ADDR_W-1:0]      WriteEdge,
    output logic [2**ADDR_W-1:0]      ReadEdge,
    output logic                      inputData,
    input  logic                      outputData
);

    localparam int CELLS = zsram_cells(ADDR_W);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    zsram_state_t r_state;
    zsram_state_t w_next;
    logic              w_accept;
    logic [ADDR_W-1:0] r_addr;
    logic              r_data;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic              w_data_nxt;
    logic              w_wr_phase;
    logic [3:0]        r_cnt;
    logic              r_ready;
    logic              r_rsp_valid;
    logic              r_rsp_data;
    logic              r_din;
    logic [CELLS-1:0]  r_wedge;
    logic [CELLS-1:0]  r_redge;
    logic [CELLS-1:0]  w_wdec;
    logic [CELLS-1:0]  w_rdec;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ReqValid) begin
                    w_accept = 1'b1;
                    w_next   = ReqWrite ? ST_WSETUP : ST_RSTROBE;
                end
            end
            ST_WSETUP:  w_next = ST_WSTROBE;
            ST_WSTROBE: w_next = ST_WHOLD;
            ST_WHOLD:   w_next = ST_IDLE;
            ST_RSTROBE: if (r_cnt == 4'd0) w_next = ST_RESP;
            ST_RESP:    if (RspReady) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Crystal50Mhz1) begin
        if (!nReset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Outputs are registered from the next-state view so they line up with the state they describe.
    assign w_addr_nxt = w_accept ? ReqAddr : r_addr;
    assign w_data_nxt = w_accept ? ReqData : r_data;
    assign w_wr_phase = (w_next == ST_WSETUP) || (w_next == ST_WSTROBE) || (w_next == ST_WHOLD);

    zsram_onehot_decoder #(.ADDR_W(ADDR_W)) u_wdec (
        .i_en     (w_next == ST_WSTROBE),
        .i_addr   (w_addr_nxt),
        .o_onehot (w_wdec)
    );

    zsram_onehot_decoder #(.ADDR_W(ADDR_W)) u_rdec (
        .i_en     (w_next == ST_RSTROBE),
        .i_addr   (w_addr_nxt),
        .o_onehot (w_rdec)
    );

    always_ff @(posedge Crystal50Mhz1) begin
        if (!nReset) begin
            r_addr      <= '0;
            r_data      <= 1'b0;
            r_cnt       <= 4'd0;
            r_ready     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 1'b0;
            r_din       <= 1'b0;
            r_wedge     <= '0;
            r_redge     <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= ReqAddr;
                r_data <= ReqData;
            end
            if (w_accept && !ReqWrite)
                r_cnt <= CNT_INIT;
            else if (r_state == ST_RSTROBE && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            // Last strobe cycle: the selected cell has had SETTLE cycles to drive the shared line.
            if (r_state == ST_RSTROBE && r_cnt == 4'd0)
                r_rsp_data <= outputData;
            r_ready     <= (w_next == ST_IDLE);
            r_rsp_valid <= (w_next == ST_RESP);
            r_din       <= w_wr_phase ? w_data_nxt : 1'b0;
            r_wedge     <= w_wdec;
            r_redge     <= w_rdec;
        end
    end

    assign ReqReady  = r_ready;
    assign RspValid  = r_rsp_valid;
    assign RspData   = r_rsp_data;
    assign WriteEdge = r_wedge;
    assign ReadEdge  = r_redge;
    assign inputData = r_din;

endmodule

// File: doc/zsram_access_sequencer.md
ZSRAM_ACCESS_SEQUENCER -- requirements
Module: zsram_access_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, the cell address width (2**ADDR_W one-bit cells).
REQ-002 The block SHALL have parameter SETTLE, default 2, the ReadEdge hold cycles before sampling (legal range 1..15).
REQ-003 The block SHALL have these ports:
- Crystal50Mhz1  in  1  clock; all logic on rising edge.
- nReset  in  1  synchronous, active-low reset.
- ReqValid  in  1  request offered.
- ReqReady  out  1  request accepted when ReqValid and ReqReady are both high.
- ReqWrite  in  1  1 = write, 0 = read.
- ReqAddr  in  ADDR_W  target cell.
- ReqData  in  1  write bit.
- RspValid  out  1  read result available.
- RspReady  in  1  consumer accepts the result.
- RspData  out  1  read bit.
- WriteEdge  out  2**ADDR_W  one-hot per-cell write strobe.
- ReadEdge  out  2**ADDR_W  one-hot per-cell read enable.
- inputData  out  1  shared write-data line to all cells.
- outputData  in  1  shared (wired) read-data line from cells.

Function
REQ-004 The FSM SHALL have states IDLE, WSETUP, WSTROBE, WHOLD, RSTROBE and RESP.
REQ-005 ReqReady SHALL be high only in IDLE; acceptance latches ReqWrite, ReqAddr and ReqData.
REQ-006 An accepted write SHALL go IDLE->WSETUP->WSTROBE->WHOLD->IDLE, one cycle per state.
REQ-007 inputData SHALL equal the latched bit from WSETUP through WHOLD and SHALL be 0 otherwise.
REQ-008 WriteEdge[addr] SHALL be high only in WSTROBE (exactly one cycle); all other WriteEdge bits SHALL stay 0.
REQ-009 A write SHALL produce no response; back-to-back writes SHALL have a throughput of one write per 4 cycles.
REQ-010 An accepted read SHALL go IDLE->RSTROBE, with ReadEdge[addr] high for exactly SETTLE cycles.
REQ-011 outputData SHALL be sampled on the last RSTROBE cycle into RspData; the FSM SHALL then enter RESP with RspValid=1.
REQ-012 In RESP, RspValid and RspData SHALL hold stable until RspReady=1; the FSM SHALL then return to IDLE, with RspValid dropping the next cycle.
REQ-013 Read latency from acceptance to RspValid SHALL be SETTLE+1 cycles.
REQ-014 If RspReady is already high on RESP entry, RspValid SHALL still be high for at least one cycle.
REQ-015 WriteEdge and ReadEdge SHALL never be nonzero in the same cycle, and each SHALL be at most one-hot.
REQ-016 The SETTLE counter SHALL be 4 bits and SHALL count down from SETTLE-1 to 0 without wrap.
REQ-017 Requests SHALL not be accepted while the FSM is in any state other than IDLE; ReqValid held high outside IDLE SHALL have no effect.

Reset
REQ-018 When nReset=0 at a clock edge, the next state SHALL be IDLE with these values: ReqReady=1, RspValid=0, RspData=0, WriteEdge=0, ReadEdge=0, inputData=0, counter=0.
REQ-019 Reset asserted mid-operation SHALL abort the access immediately, including during WSTROBE and RSTROBE; no strobe SHALL be emitted in the cycle after reset is sampled, and no response SHALL be emitted for the aborted access.
REQ-020 The first request SHALL be acceptable in the first cycle after nReset returns high.

Structure
REQ-021 A shared package zsram_pkg SHALL hold the FSM state enumeration, the default ADDR_W and SETTLE constants, and the cell-count expression 2**ADDR_W.
REQ-022 One sub-module SHALL be used: zsram_onehot_decoder (ADDR_W in, 2**ADDR_W out, with an enable input), instanced twice, once for WriteEdge and once for ReadEdge.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from Req*/RspReady inputs to WriteEdge, ReadEdge or inputData.

Verification
REQ-024 Write addr=5, data=1 -> inputData=1 for 3 cycles, WriteEdge=16'h0020 for exactly 1 cycle, ReqReady back high 4 cycles after acceptance, RspValid stays 0.
REQ-025 Read addr=5 with the cell model driving outputData=1 only while ReadEdge[5]=1, SETTLE=2 -> ReadEdge=16'h0020 for 2 cycles, RspValid=1 with RspData=1 at cycle 3 after acceptance.
REQ-026 Read with RspReady held 0 for 5 cycles -> RspValid and RspData stable for all 5 cycles, ReqReady=0 throughout, return to IDLE one cycle after RspReady=1.
REQ-027 Write addr 15 then immediately read addr 15, ReqValid held high throughout -> second acceptance exactly 4 cycles after the first, and the read returns the written bit.
REQ-028 Reset pulsed in the WSTROBE cycle of a write to addr 3 -> WriteEdge=0 in the next cycle, all outputs at reset values, ReqReady=1 one cycle after nReset rises.
REQ-029 Random mixed traffic with a 16-cell behavioural model -> every read matches the model, and the one-hot and no-overlap assertions from REQ-015 never fire.
